// File: rtl/jelly_rtos_ready_queue.sv
// Priority-sorted RTOS ready queue; one add per cycle, results (head, count, add_ack) registered one cycle after sampling.
// Losing add requests simply stay pending; optional rotate-within-priority enabled by JELLY_RTOS_READY_QUEUE_ROT_RDQ_EN.
module jelly_rtos_ready_queue #(
    parameter int TASKS        = 16,
    parameter int TSKID_WIDTH  = 4,
    parameter int TSKPRI_WIDTH = 4,
    parameter int CNT_WIDTH    = $clog2(TASKS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cke,
    input  logic [TASKS*TSKPRI_WIDTH-1:0]   tskpri,
    input  logic [TASKS-1:0]                add_req,
    output logic [TASKS-1:0]                add_ack,
    input  logic [TASKS-1:0]                rmv_req,
`ifdef JELLY_RTOS_READY_QUEUE_ROT_RDQ_EN
    input  logic [TSKPRI_WIDTH-1:0]         rot_pri,
    input  logic                            rot_valid,
`endif
    output logic [TSKID_WIDTH-1:0]          run_tskid,
    output logic                            run_valid,
    output logic [CNT_WIDTH-1:0]            que_count
);

    localparam int IDN = 1 << TSKID_WIDTH;

    logic [TASKS-1:0]        vld_q, vld_d;
    logic [TSKID_WIDTH-1:0]  id_q  [TASKS];
    logic [TSKID_WIDTH-1:0]  id_d  [TASKS];
    logic [TSKPRI_WIDTH-1:0] pri_q [TASKS];
    logic [TSKPRI_WIDTH-1:0] pri_d [TASKS];
    logic [TASKS-1:0]        ack_q, ack_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    // Stage 1: drop removed entries and compact toward entry 0.
    logic [IDN-1:0]          rmv_ext;
    logic [TASKS-1:0]        keep;
    logic [CNT_WIDTH-1:0]    pos [TASKS];
    logic [TASKS-1:0]        c_vld;
    logic [TSKID_WIDTH-1:0]  c_id  [TASKS];
    logic [TSKPRI_WIDTH-1:0] c_pri [TASKS];

    always_comb begin
        rmv_ext = IDN'(rmv_req);
        for (int j = 0; j < TASKS; j++) begin
            keep[j] = vld_q[j] && !rmv_ext[id_q[j]];
        end
        pos[0] = '0;
        for (int j = 1; j < TASKS; j++) begin
            pos[j] = pos[j-1] + CNT_WIDTH'(keep[j-1]);
        end
        for (int k = 0; k < TASKS; k++) begin
            c_vld[k] = 1'b0;
            c_id[k]  = '0;
            c_pri[k] = '0;
            for (int j = k; j < TASKS; j++) begin
                if (keep[j] && pos[j] == CNT_WIDTH'(k)) begin
                    c_vld[k] = 1'b1;
                    c_id[k]  = id_q[j];
                    c_pri[k] = pri_q[j];
                end
            end
        end
    end

    // Stage 2: optional rotate of one priority group.
    logic [TASKS-1:0]        r_vld;
    logic [TSKID_WIDTH-1:0]  r_id  [TASKS];
    logic [TSKPRI_WIDTH-1:0] r_pri [TASKS];

`ifdef JELLY_RTOS_READY_QUEUE_ROT_RDQ_EN
    logic                    f_found;
    logic [CNT_WIDTH-1:0]    f_idx, l_idx;
    logic [TSKID_WIDTH-1:0]  mv_id;

    always_comb begin
        r_vld   = c_vld;
        r_id    = c_id;
        r_pri   = c_pri;
        f_found = 1'b0;
        f_idx   = '0;
        l_idx   = '0;
        mv_id   = '0;
        for (int j = 0; j < TASKS; j++) begin
            if (c_vld[j] && c_pri[j] == rot_pri) begin
                if (!f_found) begin
                    f_found = 1'b1;
                    f_idx   = CNT_WIDTH'(j);
                    mv_id   = c_id[j];
                end
                l_idx = CNT_WIDTH'(j);
            end
        end
        // Equal priorities are contiguous, so the rotate is a left shift by one over [f_idx, l_idx].
        if (rot_valid && f_found && l_idx != f_idx) begin
            for (int j = 0; j < TASKS - 1; j++) begin
                if (CNT_WIDTH'(j) >= f_idx && CNT_WIDTH'(j) < l_idx) begin
                    r_id[j] = c_id[j+1];
                end
            end
            for (int j = 0; j < TASKS; j++) begin
                if (CNT_WIDTH'(j) == l_idx) begin
                    r_id[j] = mv_id;
                end
            end
        end
    end
`else
    always_comb begin
        r_vld = c_vld;
        r_id  = c_id;
        r_pri = c_pri;
    end
`endif

    // Stage 3: single add, lowest index wins; a task just acknowledged is still holding its request.
    logic [TASKS-1:0]        win_mask, win_oh;
    logic [TSKID_WIDTH-1:0]  w_id;
    logic [TSKPRI_WIDTH-1:0] w_pri;
    logic                    present;
    logic [CNT_WIDTH-1:0]    ins_pos;
    logic                    do_ins;

    always_comb begin
        win_mask = add_req & ~rmv_req & ~ack_q;
        win_oh   = win_mask & (~win_mask + TASKS'(1));
        w_id     = '0;
        w_pri    = '0;
        for (int i = 0; i < TASKS; i++) begin
            if (win_oh[i]) begin
                w_id  = TSKID_WIDTH'(i);
                w_pri = tskpri[i*TSKPRI_WIDTH +: TSKPRI_WIDTH];
            end
        end
        present = 1'b0;
        ins_pos = '0;
        for (int j = 0; j < TASKS; j++) begin
            if (r_vld[j] && r_id[j] == w_id) begin
                present = 1'b1;
            end
            if (r_vld[j] && r_pri[j] <= w_pri) begin
                ins_pos = ins_pos + CNT_WIDTH'(1);
            end
        end
        do_ins = (|win_oh) && !present;

        vld_d = r_vld;
        id_d  = r_id;
        pri_d = r_pri;
        if (do_ins) begin
            for (int j = 1; j < TASKS; j++) begin
                if (CNT_WIDTH'(j) > ins_pos) begin
                    vld_d[j] = r_vld[j-1];
                    id_d[j]  = r_id[j-1];
                    pri_d[j] = r_pri[j-1];
                end
            end
            for (int j = 0; j < TASKS; j++) begin
                if (CNT_WIDTH'(j) == ins_pos) begin
                    vld_d[j] = 1'b1;
                    id_d[j]  = w_id;
                    pri_d[j] = w_pri;
                end
            end
        end
        ack_d = win_oh;
        cnt_d = '0;
        for (int j = 0; j < TASKS; j++) begin
            cnt_d = cnt_d + CNT_WIDTH'(vld_d[j]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            ack_q <= '0;
            cnt_q <= '0;
            for (int j = 0; j < TASKS; j++) begin
                id_q[j]  <= '0;
                pri_q[j] <= '0;
            end
        end else if (cke) begin
            vld_q <= vld_d;
            id_q  <= id_d;
            pri_q <= pri_d;
            ack_q <= ack_d;
            cnt_q <= cnt_d;
        end
    end

    assign add_ack   = ack_q;
    assign run_tskid = id_q[0];
    assign run_valid = vld_q[0];
    assign que_count = cnt_q;

endmodule
